testdrive_axi4_read_arbiter: RTL
================================

Name: testdrive_axi4_read_arbiter

Overview:
- Round-robin arbiter sharing one AXI4 read port (AR + R channels) among C_PORT_COUNT requesters, for testbench tops where several DUT masters share one AXI4 BFM.
- At most one outstanding burst at a time; the owning requester holds the port from AR acceptance through its RLAST beat.
- Checks burst length and RID consistency and flags violations on a sticky error output.

Parameters:
C_PORT_COUNT, 4, number of requesters (2..16)
C_THREAD_ID_WIDTH, 1, AXI ID width
C_ADDR_WIDTH, 32, address width
C_DATA_WIDTH, 128, data width
C_USE_AXI4, 1, 1: AxLEN is 8 bits; 0: AxLEN is 4 bits (LW below)

Ports:
- Clock and reset (already decided): one clock; reset is asynchronous and active-low.
CLK  in  1  clock
nRST  in  1  asynchronous reset, active low
- Requester side (fields packed per port; port i occupies slice i):
S_ARID  in  N*IDW  per-port read ID
S_ARADDR  in  N*AW  per-port address
S_ARLEN  in  N*LW  per-port burst length-1
S_ARSIZE  in  N*3  per-port size
S_ARBURST  in  N*2  per-port burst type
S_ARVALID  in  N  per-port AR valid
S_ARREADY  out  N  per-port AR ready (one-hot or zero)
S_RID  out  IDW  broadcast RID
S_RDATA  out  DW  broadcast RDATA
S_RRESP  out  2  broadcast RRESP
S_RLAST  out  1  broadcast RLAST
S_RVALID  out  N  per-port R valid (owner only)
S_RREADY  in  N  per-port R ready
- Shared port side:
M_ARID  out  IDW  latched ID
M_ARADDR  out  AW  latched address
M_ARLEN  out  LW  latched length
M_ARSIZE  out  3  latched size
M_ARBURST  out  2  latched burst
M_ARVALID  out  1  AR valid
M_ARREADY  in  1  AR ready
M_RID  in  IDW  read ID
M_RDATA  in  DW  read data
M_RRESP  in  2  read response
M_RLAST  in  1  read last
M_RVALID  in  1  read valid
M_RREADY  out  1  read ready
- Status:
ERR  out  1  sticky protocol error
ERR_PORT  out  clog2(N)  owner at first error

Behaviour:
- FSM with states IDLE, ADDR, DATA; registers owner, last_grant, beat_cnt, and latched AR fields.
- Reset values:
  - State IDLE; last_grant = N-1, so port 0 has first priority.
  - M_ARVALID, M_AR* fields, beat_cnt, ERR and ERR_PORT all 0.
  - S_ARREADY = 0, S_RVALID = 0, M_RREADY = 0.
- IDLE:
  - Grant g = first port with S_ARVALID set, searching cyclically from last_grant+1.
  - S_ARREADY[g] is driven combinationally in that same cycle, so the requester's handshake completes on that edge.
  - On that edge: latch port g's fields into M_AR*, owner <= g, M_ARVALID <= 1, beat_cnt <= 0, go to ADDR.
  - With no request, stay in IDLE.
- ADDR:
  - M_AR* held stable; S_ARREADY all 0.
  - On M_ARVALID & M_ARREADY: M_ARVALID <= 0, go to DATA.
- DATA:
  - S_RVALID[owner] = M_RVALID; M_RREADY = S_RREADY[owner]; all other S_RVALID bits 0.
  - S_RID/S_RDATA/S_RRESP/S_RLAST = M_R* passthrough to all ports.
  - Each R handshake increments beat_cnt (LW bits).
  - On a handshake with M_RLAST: last_grant <= owner, go to IDLE.
- Latency and ordering:
  - S_ARVALID at cycle t (IDLE) gives M_ARVALID at t+1.
  - After RLAST accepted at t, the next grant can occur at t+1.
  - R data path is purely combinational (0 cycles).
- Errors (first error sets ERR=1 and captures ERR_PORT=owner; later errors do not change ERR_PORT; operation continues):
  - M_RLAST on a beat with beat_cnt != latched ARLEN.
  - A beat with beat_cnt == ARLEN and no M_RLAST; the FSM then stays in DATA until RLAST arrives.
  - M_RID != latched ARID on any beat.
  - M_RVALID asserted outside DATA; such beats are not routed and M_RREADY stays 0.
- Simultaneous requests: only the granted port sees ready; the others keep ARVALID asserted and wait.
- Requests arriving in ADDR or DATA are not accepted until the next IDLE.
- Reset mid-burst: all state returns to reset values immediately. The in-flight burst is abandoned; the shared port must also be reset.

Test Plan:
- Single request: port 2 ARADDR=0x1000, ARLEN=3 -> S_ARREADY=4'b0100 in request cycle; M_ARVALID next cycle with ADDR 0x1000, LEN 3; 4 beats routed only to S_RVALID[2]; IDLE after beat 4; ERR=0.
- Fairness: all 4 ports request continuously with ARLEN=0 -> grant order 0,1,2,3,0,1; each burst cycle is 3 cycles with M_ARREADY=1 and immediate R.
- Backpressure: M_ARREADY low for 5 cycles, then S_RREADY[owner] toggling -> M_AR* stable throughout, no beat lost, beat_cnt reaches 7 for ARLEN=7.
- Length error: ARLEN=3, slave asserts RLAST on beat 2 -> ERR=1, ERR_PORT=owner, FSM returns to IDLE; next burst proceeds normally.
- RID error: ARID=1 latched, slave returns RID=0 -> ERR=1.
- Reset: nRST pulsed low mid-DATA -> all outputs 0 asynchronously; after release, port 0 wins a tie against port 3.

Source files
------------

// File: rtl/testdrive_axi4_read_arbiter.sv
// Round-robin arbiter sharing one AXI4 read port (AR + R) among several requesters.
// One burst in flight at a time; RLAST/length/RID consistency is flagged on a sticky ERR.
module testdrive_axi4_read_arbiter #(
  parameter int C_PORT_COUNT      = 4,
  parameter int C_THREAD_ID_WIDTH = 1,
  parameter int C_ADDR_WIDTH      = 32,
  parameter int C_DATA_WIDTH      = 128,
  parameter int C_USE_AXI4        = 1,
  localparam int N   = C_PORT_COUNT,
  localparam int IDW = C_THREAD_ID_WIDTH,
  localparam int AW  = C_ADDR_WIDTH,
  localparam int DW  = C_DATA_WIDTH,
  localparam int LW  = (C_USE_AXI4 != 0) ? 8 : 4,
  localparam int PW  = $clog2(C_PORT_COUNT)
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic [N*IDW-1:0]   S_ARID,
  input  logic [N*AW-1:0]    S_ARADDR,
  input  logic [N*LW-1:0]    S_ARLEN,
  input  logic [N*3-1:0]     S_ARSIZE,
  input  logic [N*2-1:0]     S_ARBURST,
  input  logic [N-1:0]       S_ARVALID,
  output logic [N-1:0]       S_ARREADY,
  output logic [IDW-1:0]     S_RID,
  output logic [DW-1:0]      S_RDATA,
  output logic [1:0]         S_RRESP,
  output logic               S_RLAST,
  output logic [N-1:0]       S_RVALID,
  input  logic [N-1:0]       S_RREADY,
  output logic [IDW-1:0]     M_ARID,
  output logic [AW-1:0]      M_ARADDR,
  output logic [LW-1:0]      M_ARLEN,
  output logic [2:0]         M_ARSIZE,
  output logic [1:0]         M_ARBURST,
  output logic               M_ARVALID,
  input  logic               M_ARREADY,
  input  logic [IDW-1:0]     M_RID,
  input  logic [DW-1:0]      M_RDATA,
  input  logic [1:0]         M_RRESP,
  input  logic               M_RLAST,
  input  logic               M_RVALID,
  output logic               M_RREADY,
  output logic               ERR,
  output logic [PW-1:0]      ERR_PORT
);

  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA} state_e;

  state_e         state_q, state_d;
  logic [PW-1:0]  owner_q, owner_d;
  logic [PW-1:0]  last_grant_q, last_grant_d;
  logic [PW-1:0]  err_port_q, err_port_d;
  logic [LW-1:0]  beat_cnt_q, beat_cnt_d;
  logic [IDW-1:0] arid_q, arid_d;
  logic [AW-1:0]  araddr_q, araddr_d;
  logic [LW-1:0]  arlen_q, arlen_d;
  logic [2:0]     arsize_q, arsize_d;
  logic [1:0]     arburst_q, arburst_d;
  logic           arvalid_q, arvalid_d;
  logic           err_q, err_d;

  logic           grant_found;
  logic [PW-1:0]  grant_idx;
  logic [IDW-1:0] sel_id;
  logic [AW-1:0]  sel_addr;
  logic [LW-1:0]  sel_len;
  logic [2:0]     sel_size;
  logic [1:0]     sel_burst;
  logic           ar_accept;
  logic           route_r;
  logic           owner_rready;
  logic           r_hs;
  logic           err_event;

  // Lowest port above last_grant wins; otherwise wrap to the lowest port at or below it.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (S_ARVALID[i] && (PW'(i) <= last_grant_q)) begin
        grant_found = 1'b1;
        grant_idx   = PW'(i);
      end
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (S_ARVALID[i] && (PW'(i) > last_grant_q)) begin
        grant_found = 1'b1;
        grant_idx   = PW'(i);
      end
    end
  end

  always_comb begin
    sel_id    = '0;
    sel_addr  = '0;
    sel_len   = '0;
    sel_size  = '0;
    sel_burst = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_idx == PW'(i)) begin
        sel_id    = S_ARID[i*IDW +: IDW];
        sel_addr  = S_ARADDR[i*AW +: AW];
        sel_len   = S_ARLEN[i*LW +: LW];
        sel_size  = S_ARSIZE[i*3 +: 3];
        sel_burst = S_ARBURST[i*2 +: 2];
      end
    end
  end

  // State register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= ST_IDLE;
      owner_q      <= '0;
      last_grant_q <= PW'(N - 1);
      err_port_q   <= '0;
      beat_cnt_q   <= '0;
      arid_q       <= '0;
      araddr_q     <= '0;
      arlen_q      <= '0;
      arsize_q     <= '0;
      arburst_q    <= '0;
      arvalid_q    <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      err_port_q   <= err_port_d;
      beat_cnt_q   <= beat_cnt_d;
      arid_q       <= arid_d;
      araddr_q     <= araddr_d;
      arlen_q      <= arlen_d;
      arsize_q     <= arsize_d;
      arburst_q    <= arburst_d;
      arvalid_q    <= arvalid_d;
      err_q        <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    err_port_d   = err_port_q;
    beat_cnt_d   = beat_cnt_q;
    arid_d       = arid_q;
    araddr_d     = araddr_q;
    arlen_d      = arlen_q;
    arsize_d     = arsize_q;
    arburst_d    = arburst_q;
    arvalid_d    = arvalid_q;
    err_d        = err_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_found) begin
          state_d    = ST_ADDR;
          owner_d    = grant_idx;
          arvalid_d  = 1'b1;
          beat_cnt_d = '0;
          arid_d     = sel_id;
          araddr_d   = sel_addr;
          arlen_d    = sel_len;
          arsize_d   = sel_size;
          arburst_d  = sel_burst;
        end
      end
      ST_ADDR: begin
        if (arvalid_q && M_ARREADY) begin
          arvalid_d = 1'b0;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (r_hs) begin
          beat_cnt_d = beat_cnt_q + LW'(1);
          // A missing RLAST keeps us here; only RLAST releases the port.
          if (M_RLAST) begin
            last_grant_d = owner_q;
            state_d      = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (err_event && !err_q) begin
      err_d      = 1'b1;
      err_port_d = owner_q;
    end
  end

  // Output / routing logic
  always_comb begin
    ar_accept    = nRST && (state_q == ST_IDLE) && grant_found;
    route_r      = (state_q == ST_DATA) && M_RVALID;
    owner_rready = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (owner_q == PW'(i)) owner_rready = S_RREADY[i];
    end
    M_RREADY  = (state_q == ST_DATA) && owner_rready;
    r_hs      = route_r && owner_rready;
    err_event = 1'b0;
    if (r_hs) begin
      if (M_RLAST != (beat_cnt_q == arlen_q)) err_event = 1'b1;
      if (M_RID != arid_q)                    err_event = 1'b1;
    end
    if (M_RVALID && (state_q != ST_DATA)) err_event = 1'b1;
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_port
    assign S_ARREADY[gi] = ar_accept && (grant_idx == PW'(gi));
    assign S_RVALID[gi]  = route_r && (owner_q == PW'(gi));
  end

  assign S_RID     = M_RID;
  assign S_RDATA   = M_RDATA;
  assign S_RRESP   = M_RRESP;
  assign S_RLAST   = M_RLAST;
  assign M_ARID    = arid_q;
  assign M_ARADDR  = araddr_q;
  assign M_ARLEN   = arlen_q;
  assign M_ARSIZE  = arsize_q;
  assign M_ARBURST = arburst_q;
  assign M_ARVALID = arvalid_q;
  assign ERR       = err_q;
  assign ERR_PORT  = err_port_q;

endmodule
